// File: rtl/peripheral_bfm_ahb4_pkg.sv
// peripheral_bfm_ahb4_pkg: shared types and constants for the AHB4-style bus master BFM.
// Contents: the FSM state encoding, response codes, burst and size codes,
// and the response-severity merge used to build the completion status.
package peripheral_bfm_ahb4_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WADDR = 3'd1,
      ST_WDATA = 3'd2,
      ST_WRESP = 3'd3,
      ST_RADDR = 3'd4,
      ST_RDATA = 3'd5
   } bfm_state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [2:0] SIZE_WORD  = 3'b010;

   // Most severe of two responses (DECERR > SLVERR > EXOKAY > OKAY).
   function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
      logic [1:0] r;
      if ((a == RESP_DECERR) || (b == RESP_DECERR)) begin
         r = RESP_DECERR;
      end else if ((a == RESP_SLVERR) || (b == RESP_SLVERR)) begin
         r = RESP_SLVERR;
      end else if ((a == RESP_EXOKAY) || (b == RESP_EXOKAY)) begin
         r = RESP_EXOKAY;
      end else begin
         r = RESP_OKAY;
      end
      return r;
   endfunction

endpackage

// File: rtl/peripheral_bfm_master_ahb4.sv
// peripheral_bfm_master_ahb4: command-driven bus master, one transaction in flight.
// A queued command (single or INCR burst, 1-16 beats) becomes a full channel-level
// write (AW, W, B) or read (AR, R) transaction with a one-cycle completion pulse.
// Build option PERIPHERAL_BFM_ID_CHECK_EN: bid/rid are compared with the issued ID;
// a mismatch forces SLVERR on completion and sets the sticky id_err output.
module peripheral_bfm_master_ahb4
   import peripheral_bfm_ahb4_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
) (
   input  logic                aclk,
   input  logic                areset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_write,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [3:0]          cmd_len,
   input  logic [ID_W-1:0]     cmd_id,
   input  logic                wdat_valid,
   output logic                wdat_ready,
   input  logic [DATA_W-1:0]   wdat_data,
   input  logic [DATA_W/8-1:0] wdat_strb,
   output logic                rd_valid,
   input  logic                rd_ready,
   output logic [DATA_W-1:0]   rd_data,
   output logic                rd_last,
   output logic [1:0]          rd_resp,
   output logic                done_valid,
   output logic [1:0]          done_resp,
   output logic [ID_W-1:0]     done_id,
`ifdef PERIPHERAL_BFM_ID_CHECK_EN
   output logic                id_err,
`endif
   output logic [ID_W-1:0]     awid,
   output logic [ADDR_W-1:0]   awadr,
   output logic [3:0]          awlen,
   output logic [2:0]          awsize,
   output logic [1:0]          awburst,
   output logic [1:0]          awlock,
   output logic [3:0]          awcache,
   output logic [2:0]          awprot,
   output logic                awvalid,
   input  logic                awready,
   output logic [ID_W-1:0]     wid,
   output logic [DATA_W-1:0]   wrdata,
   output logic [DATA_W/8-1:0] wstrb,
   output logic                wlast,
   output logic                wvalid,
   input  logic                wready,
   input  logic [ID_W-1:0]     bid,
   input  logic [1:0]          bresp,
   input  logic                bvalid,
   output logic                bready,
   output logic [ID_W-1:0]     arid,
   output logic [ADDR_W-1:0]   araddr,
   output logic [3:0]          arlen,
   output logic [2:0]          arsize,
   output logic [1:0]          arlock,
   output logic [3:0]          arcache,
   output logic [2:0]          arprot,
   output logic                arvalid,
   input  logic                arready,
   input  logic [ID_W-1:0]     rid,
   input  logic [DATA_W-1:0]   rdata,
   input  logic [1:0]          rresp,
   input  logic                rlast,
   input  logic                rvalid,
   output logic                rready
);

   localparam logic [2:0] BEAT_SIZE = (DATA_W == 32) ? SIZE_WORD : 3'($clog2(DATA_W / 32'd8));

   bfm_state_t        state_r;
   logic [ADDR_W-1:0] addr_r;
   logic [3:0]        len_r;
   logic [ID_W-1:0]   id_r;
   logic [3:0]        beat_cnt_r;
   logic [1:0]        worst_r;
   logic              id_mis_r;
   logic              cmd_ready_r;
   logic              awvalid_r;
   logic              arvalid_r;
   logic              bready_r;
   logic              done_valid_r;
   logic [1:0]        done_resp_r;
   logic [ID_W-1:0]   done_id_r;

   logic              in_wdata_s;
   logic              in_rdata_s;
   logic              w_hs_s;
   logic              r_hs_s;
   logic              last_beat_s;
   logic              bid_bad_s;
   logic              rid_bad_s;
   logic [1:0]        r_worst_s;
   logic [1:0]        rd_done_resp_s;

   assign in_wdata_s  = (state_r == ST_WDATA);
   assign in_rdata_s  = (state_r == ST_RDATA);
   assign last_beat_s = (beat_cnt_r == len_r);
   assign w_hs_s      = in_wdata_s & wdat_valid & wready;
   assign r_hs_s      = in_rdata_s & rvalid & rd_ready;
   assign r_worst_s   = worst_resp(worst_r, rresp);

`ifdef PERIPHERAL_BFM_ID_CHECK_EN
   assign bid_bad_s = (bid != id_r);
   assign rid_bad_s = (rid != id_r);
`else
   logic unused_id_s;
   assign bid_bad_s   = 1'b0;
   assign rid_bad_s   = 1'b0;
   assign unused_id_s = ^{bid, rid};
`endif

   // Completion status of a read on its final accepted beat.
   always_comb begin
      rd_done_resp_s = r_worst_s;
      if (!rlast) begin
         // Beat budget exhausted without rlast from the slave.
         rd_done_resp_s = RESP_SLVERR;
      end else if (id_mis_r || rid_bad_s) begin
         rd_done_resp_s = RESP_SLVERR;
      end else begin
         rd_done_resp_s = r_worst_s;
      end
   end

   // Transaction sequencer: state, captured command and registered handshake outputs.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_r      <= ST_IDLE;
         addr_r       <= {ADDR_W{1'b0}};
         len_r        <= 4'd0;
         id_r         <= {ID_W{1'b0}};
         beat_cnt_r   <= 4'd0;
         worst_r      <= RESP_OKAY;
         id_mis_r     <= 1'b0;
         cmd_ready_r  <= 1'b0;
         awvalid_r    <= 1'b0;
         arvalid_r    <= 1'b0;
         bready_r     <= 1'b0;
         done_valid_r <= 1'b0;
         done_resp_r  <= RESP_OKAY;
         done_id_r    <= {ID_W{1'b0}};
      end else begin
         done_valid_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (cmd_ready_r && cmd_valid) begin
                  addr_r      <= cmd_addr;
                  len_r       <= cmd_len;
                  id_r        <= cmd_id;
                  cmd_ready_r <= 1'b0;
                  if (cmd_write) begin
                     awvalid_r <= 1'b1;
                     state_r   <= ST_WADDR;
                  end else begin
                     arvalid_r <= 1'b1;
                     state_r   <= ST_RADDR;
                  end
               end else begin
                  cmd_ready_r <= 1'b1;
               end
            end
            ST_WADDR: begin
               if (awready) begin
                  awvalid_r  <= 1'b0;
                  beat_cnt_r <= 4'd0;
                  state_r    <= ST_WDATA;
               end
            end
            ST_WDATA: begin
               if (w_hs_s) begin
                  if (last_beat_s) begin
                     bready_r <= 1'b1;
                     state_r  <= ST_WRESP;
                  end else begin
                     beat_cnt_r <= beat_cnt_r + 4'd1;
                  end
               end
            end
            ST_WRESP: begin
               if (bvalid) begin
                  bready_r     <= 1'b0;
                  done_valid_r <= 1'b1;
                  done_resp_r  <= bid_bad_s ? RESP_SLVERR : bresp;
                  done_id_r    <= id_r;
                  state_r      <= ST_IDLE;
               end
            end
            ST_RADDR: begin
               if (arready) begin
                  arvalid_r  <= 1'b0;
                  beat_cnt_r <= 4'd0;
                  worst_r    <= RESP_OKAY;
                  id_mis_r   <= 1'b0;
                  state_r    <= ST_RDATA;
               end
            end
            ST_RDATA: begin
               if (r_hs_s) begin
                  worst_r  <= r_worst_s;
                  id_mis_r <= id_mis_r | rid_bad_s;
                  if (rlast || last_beat_s) begin
                     done_valid_r <= 1'b1;
                     done_resp_r  <= rd_done_resp_s;
                     done_id_r    <= id_r;
                     state_r      <= ST_IDLE;
                  end else begin
                     beat_cnt_r <= beat_cnt_r + 4'd1;
                  end
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               cmd_ready_r <= 1'b0;
               awvalid_r   <= 1'b0;
               arvalid_r   <= 1'b0;
               bready_r    <= 1'b0;
            end
         endcase
      end
   end

`ifdef PERIPHERAL_BFM_ID_CHECK_EN
   logic id_err_r;

   // Sticky flag: any write or read response that carried a foreign ID.
   always_ff @(posedge aclk) begin
      if (areset) begin
         id_err_r <= 1'b0;
      end else if (((state_r == ST_WRESP) && bvalid && bid_bad_s) || (r_hs_s && rid_bad_s)) begin
         id_err_r <= 1'b1;
      end else begin
         id_err_r <= id_err_r;
      end
   end

   assign id_err = id_err_r;
`endif

   assign cmd_ready  = cmd_ready_r;
   assign done_valid = done_valid_r;
   assign done_resp  = done_resp_r;
   assign done_id    = done_id_r;

   assign awid    = id_r;
   assign awadr   = addr_r;
   assign awlen   = len_r;
   assign awsize  = BEAT_SIZE;
   assign awburst = BURST_INCR;
   assign awlock  = 2'b00;
   assign awcache = 4'b0000;
   assign awprot  = 3'b000;
   assign awvalid = awvalid_r;

   // Write data is a pass-through from the stream side while the data phase is open.
   assign wid        = id_r;
   assign wvalid     = in_wdata_s & wdat_valid;
   assign wdat_ready = in_wdata_s & wready;
   assign wrdata     = in_wdata_s ? wdat_data : {DATA_W{1'b0}};
   assign wstrb      = in_wdata_s ? wdat_strb : {(DATA_W/8){1'b0}};
   assign wlast      = in_wdata_s & last_beat_s;
   assign bready     = bready_r;

   assign arid    = id_r;
   assign araddr  = addr_r;
   assign arlen   = len_r;
   assign arsize  = BEAT_SIZE;
   assign arlock  = 2'b00;
   assign arcache = 4'b0000;
   assign arprot  = 3'b000;
   assign arvalid = arvalid_r;

   // Read data is a pass-through to the stream side while the data phase is open.
   assign rready   = in_rdata_s & rd_ready;
   assign rd_valid = in_rdata_s & rvalid;
   assign rd_data  = in_rdata_s ? rdata : {DATA_W{1'b0}};
   assign rd_resp  = in_rdata_s ? rresp : RESP_OKAY;
   assign rd_last  = in_rdata_s & rlast;

endmodule

// File: tb/tb_peripheral_bfm_master_ahb4.sv
// tb_peripheral_bfm_master_ahb4: self-checking bench for peripheral_bfm_master_ahb4.
// Plays both the command/stream side and a slave on the bus channels, cycle by cycle.
// Honours PERIPHERAL_BFM_ID_CHECK_EN (connects and checks id_err when defined).
module tb_peripheral_bfm_master_ahb4;

`ifdef PERIPHERAL_BFM_ID_CHECK_EN
   localparam bit ID_CHK = 1'b1;
`else
   localparam bit ID_CHK = 1'b0;
`endif

   logic        aclk = 1'b0;
   logic        areset;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr;
   logic [3:0]  cmd_len, cmd_id;
   logic        wdat_valid, wdat_ready;
   logic [31:0] wdat_data;
   logic [3:0]  wdat_strb;
   logic        rd_valid, rd_ready, rd_last;
   logic [31:0] rd_data;
   logic [1:0]  rd_resp;
   logic        done_valid;
   logic [1:0]  done_resp;
   logic [3:0]  done_id;
   logic        id_err;
   logic [3:0]  awid, awlen, awcache;
   logic [31:0] awadr;
   logic [2:0]  awsize, awprot;
   logic [1:0]  awburst, awlock;
   logic        awvalid, awready;
   logic [3:0]  wid, wstrb;
   logic [31:0] wrdata;
   logic        wlast, wvalid, wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid, bready;
   logic [3:0]  arid, arlen, arcache;
   logic [31:0] araddr;
   logic [2:0]  arsize, arprot;
   logic [1:0]  arlock;
   logic        arvalid, arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast, rvalid, rready;

   always #5 aclk = ~aclk;

   peripheral_bfm_master_ahb4 dut (
      .aclk(aclk), .areset(areset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
      .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat_data(wdat_data), .wdat_strb(wdat_strb),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last), .rd_resp(rd_resp),
      .done_valid(done_valid), .done_resp(done_resp), .done_id(done_id),
`ifdef PERIPHERAL_BFM_ID_CHECK_EN
      .id_err(id_err),
`endif
      .awid(awid), .awadr(awadr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wid(wid), .wrdata(wrdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arlock(arlock),
      .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

`ifndef PERIPHERAL_BFM_ID_CHECK_EN
   assign id_err = 1'b0;
`endif

   int checks = 0;
   int errors = 0;
   bit sticky_exp = 1'b0;

   logic [31:0] wdata_a [16];
   logic [3:0]  wstrb_a [16];
   logic [31:0] rdata_a [16];
   logic [1:0]  rresp_a [16];

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [3:0]  len;
      logic [3:0]  id;
      logic [1:0]  bresp;
      int          rlast_at;
      int          bad_beat;
      logic [1:0]  bad_resp;
      bit          bad_id;
      int          mode;
      logic [1:0]  exp_resp;
      int          exp_beats;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic coin();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic idle_inputs();
      cmd_valid = 1'b0; wdat_valid = 1'b0; bvalid = 1'b0; rvalid = 1'b0; rlast = 1'b0;
      awready = 1'b0; wready = 1'b0; arready = 1'b0; rd_ready = 1'b0;
   endtask

   function automatic void fill_data();
      for (int i = 0; i < 16; i++) begin
         wdata_a[i] = $urandom;
         wstrb_a[i] = 4'($urandom_range(0, 15));
         rdata_a[i] = $urandom;
         rresp_a[i] = 2'b00;
      end
   endfunction

   // Reference: a read completes on rlast or after len+1 beats; no rlast in budget => SLVERR,
   // otherwise the most severe response seen; a foreign ID (checked build) => SLVERR.
   function automatic logic [1:0] model_resp(bit wr, logic [1:0] bresp_v, bit bad_id,
                                            int len, int rlast_at);
      logic [1:0] w;
      if (wr) return (bad_id && ID_CHK) ? 2'b10 : bresp_v;
      if (rlast_at > len) return 2'b10;
      w = 2'b00;
      for (int i = 0; i <= rlast_at; i++) if (rresp_a[i] > w) w = rresp_a[i];
      if (bad_id && ID_CHK) w = 2'b10;
      return w;
   endfunction

   function automatic int model_beats(bit wr, int len, int rlast_at);
      if (wr || rlast_at > len) return len + 1;
      return rlast_at + 1;
   endfunction

   // One complete transaction. mode: 0 all ready, 1 random throttling, 2 wready stalls 2 cycles
   // on beat 2. abort_at > 0 pulses areset once abort_at W beats have been accepted.
   task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [3:0] len,
                         input logic [3:0] id, input logic [1:0] bresp_v, input int rlast_at,
                         input bit bad_id, input int mode, input int abort_at,
                         input logic [1:0] exp_resp, input int exp_beats);
      bit cmd_sent = 0, aw_done = 0, ar_done = 0, b_done = 0, r_fin = 0, done_seen = 0;
      bit in_w, in_r;
      int wb = 0, rb = 0, aw_cnt = 0, ar_cnt = 0, done_cnt = 0, cyc = 0, stall = 0;
      logic [1:0] got_resp = 2'b00;
      logic [3:0] got_id = 4'h0;
      logic [3:0] rsp_id;
      rsp_id = bad_id ? (id ^ 4'h6) : id;
      while (1) begin
         @(negedge aclk);
         cyc++;
         if (cyc > 800) begin
            checks++; errors++;
            $display("FAIL txn_timeout cycles=%0d limit=%0d", cyc, 800);
            idle_inputs(); areset = 1'b1; @(negedge aclk); areset = 1'b0; sticky_exp = 1'b0;
            return;
         end
         if (done_seen) begin
            chk("done_single_pulse", done_valid, 1'b0);
            chk("cmd_ready_after_done", cmd_ready, 1'b1);
            chk("idle_bready", bready, 1'b0);
            chk("idle_awvalid", awvalid, 1'b0);
            chk("idle_arvalid", arvalid, 1'b0);
            idle_inputs();
            break;
         end
         if (done_valid) begin
            done_cnt++; got_resp = done_resp; got_id = done_id; done_seen = 1;
         end
         if (abort_at > 0 && wb == abort_at) begin
            areset = 1'b1; wdat_valid = 1'b1; wready = 1'b1; rd_ready = 1'b1; rvalid = 1'b1;
            @(negedge aclk);
            chk("rst_awvalid", awvalid, 1'b0); chk("rst_wvalid", wvalid, 1'b0);
            chk("rst_wlast", wlast, 1'b0);     chk("rst_wdat_ready", wdat_ready, 1'b0);
            chk("rst_bready", bready, 1'b0);   chk("rst_arvalid", arvalid, 1'b0);
            chk("rst_rready", rready, 1'b0);   chk("rst_rd_valid", rd_valid, 1'b0);
            chk("rst_done", done_valid, 1'b0); chk("rst_cmd_ready", cmd_ready, 1'b0);
            chk("rst_awadr", awadr, 32'h0);    chk("rst_awlen", awlen, 4'h0);
            areset = 1'b0; idle_inputs(); sticky_exp = 1'b0;
            return;
         end
         cmd_valid = !cmd_sent; cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_id = id;
         awready = (mode == 1) ? coin() : 1'b1;
         arready = (mode == 1) ? coin() : 1'b1;
         wdat_valid = (wr && wb <= len) ? ((mode == 1) ? coin() : 1'b1) : 1'b0;
         wdat_data = (wb <= len) ? wdata_a[wb] : 32'h0;
         wdat_strb = (wb <= len) ? wstrb_a[wb] : 4'h0;
         if (mode == 2 && wb == 1 && stall < 2) begin
            wready = 1'b0; stall++;
         end else begin
            wready = (mode == 1) ? coin() : 1'b1;
         end
         bvalid = wr && aw_done && (wb > len) && !b_done && ((mode == 1) ? coin() : 1'b1);
         bresp = bresp_v; bid = rsp_id;
         rvalid = !wr && ar_done && !r_fin && ((mode == 1) ? coin() : 1'b1);
         rdata = (rb < 16) ? rdata_a[rb] : 32'h0;
         rresp = (rb < 16) ? rresp_a[rb] : 2'b00;
         rlast = (rb == rlast_at); rid = rsp_id;
         rd_ready = (mode == 1) ? coin() : 1'b1;
         #1;
         in_w = wr && aw_done && (wb <= len);
         in_r = !wr && ar_done && !r_fin;
         chk("wvalid", wvalid, in_w ? wdat_valid : 1'b0);
         chk("wdat_ready", wdat_ready, in_w ? wready : 1'b0);
         chk("rready", rready, in_r ? rd_ready : 1'b0);
         chk("rd_valid", rd_valid, in_r ? rvalid : 1'b0);
         if (in_w) begin
            chk("wrdata", wrdata, wdata_a[wb]); chk("wstrb", wstrb, wstrb_a[wb]);
            chk("wlast", wlast, wb == len);    chk("wid", wid, id);
         end
         if (in_r && rvalid) begin
            chk("rd_data", rd_data, rdata_a[rb]); chk("rd_resp", rd_resp, rresp_a[rb]);
            chk("rd_last", rd_last, rb == rlast_at);
         end
         if (cmd_valid && cmd_ready) cmd_sent = 1;
         if (awvalid && awready) begin
            aw_cnt++; aw_done = 1;
            chk("awadr", awadr, addr); chk("awlen", awlen, len); chk("awid", awid, id);
            chk("awsize", awsize, 3'b010); chk("awburst", awburst, 2'b01);
            chk("aw_lcp", {awlock, awcache, awprot}, 9'h0);
         end
         if (arvalid && arready) begin
            ar_cnt++; ar_done = 1;
            chk("araddr", araddr, addr); chk("arlen", arlen, len); chk("arid", arid, id);
            chk("arsize", arsize, 3'b010); chk("ar_lcp", {arlock, arcache, arprot}, 9'h0);
         end
         if (in_w && wdat_valid && wready) wb++;
         if (bvalid && bready) b_done = 1;
         if (in_r && rvalid && rd_ready) begin
            if (rlast || rb == int'(len)) r_fin = 1;
            rb++;
         end
      end
      chk("done_count", done_cnt, 1);
      chk("done_resp", got_resp, exp_resp);
      chk("done_id", got_id, id);
      chk("beats", wr ? wb : rb, exp_beats);
      chk("aw_count", aw_cnt, wr ? 1 : 0);
      chk("ar_count", ar_cnt, wr ? 0 : 1);
      if (bad_id && ID_CHK) sticky_exp = 1'b1;
      chk("id_err", id_err, sticky_exp);
   endtask

   initial begin
      // wr addr len id bresp rlast_at bad_beat bad_resp bad_id mode exp_resp exp_beats
      tbl[0] = '{1'b1, 32'h100,  4'd0,  4'd3, 2'b00, 0,  -1, 2'b00, 1'b0, 0, 2'b00, 1};
      tbl[1] = '{1'b1, 32'h2000, 4'd3,  4'd5, 2'b00, 3,  -1, 2'b00, 1'b0, 2, 2'b00, 4};
      tbl[2] = '{1'b0, 32'h3000, 4'd15, 4'd2, 2'b00, 15, -1, 2'b00, 1'b0, 1, 2'b00, 16};
      tbl[3] = '{1'b0, 32'h400,  4'd3,  4'd7, 2'b00, 3,  1,  2'b10, 1'b0, 0, 2'b10, 4};
      tbl[4] = '{1'b1, 32'h500,  4'd1,  4'd1, 2'b11, 1,  -1, 2'b00, 1'b0, 1, 2'b11, 2};
      tbl[5] = '{1'b0, 32'h600,  4'd3,  4'd4, 2'b00, 1,  -1, 2'b00, 1'b0, 0, 2'b00, 2};
      tbl[6] = '{1'b0, 32'h700,  4'd2,  4'd6, 2'b00, 99, -1, 2'b00, 1'b0, 1, 2'b10, 3};
      tbl[7] = '{1'b0, 32'h800,  4'd1,  4'd9, 2'b00, 1,  0,  2'b01, 1'b0, 0, 2'b01, 2};
      tbl[8] = '{1'b0, 32'h900,  4'd3,  4'd3, 2'b00, 3,  -1, 2'b00, 1'b1, 0,
                 ID_CHK ? 2'b10 : 2'b00, 4};
      tbl[9] = '{1'b1, 32'hA00,  4'd0,  4'd3, 2'b01, 0,  -1, 2'b00, 1'b1, 0,
                 ID_CHK ? 2'b10 : 2'b01, 1};

      idle_inputs();
      cmd_write = 1'b0; cmd_addr = 32'h0; cmd_len = 4'h0; cmd_id = 4'h0;
      wdat_data = 32'h0; wdat_strb = 4'h0; bid = 4'h0; bresp = 2'b00;
      rid = 4'h0; rdata = 32'h0; rresp = 2'b00;
      areset = 1'b1; wdat_valid = 1'b1; wready = 1'b1; rd_ready = 1'b1; rvalid = 1'b1;
      repeat (2) @(negedge aclk);
      chk("reset_cmd_ready", cmd_ready, 1'b0);
      chk("reset_valids", {awvalid, arvalid, wvalid, rd_valid, done_valid}, 5'h0);
      chk("reset_readies", {bready, rready, wdat_ready}, 3'h0);
      chk("reset_wlast", wlast, 1'b0);
      chk("reset_regs", {awadr, awlen, awid}, 40'h0);
      areset = 1'b0; idle_inputs();
      @(negedge aclk);
      chk("idle_cmd_ready", cmd_ready, 1'b1);

      for (int i = 0; i < 10; i++) begin
         fill_data();
         if (tbl[i].bad_beat >= 0) rresp_a[tbl[i].bad_beat] = tbl[i].bad_resp;
         do_txn(tbl[i].wr, tbl[i].addr, tbl[i].len, tbl[i].id, tbl[i].bresp, tbl[i].rlast_at,
                tbl[i].bad_id, tbl[i].mode, 0, tbl[i].exp_resp, tbl[i].exp_beats);
      end

      // Reset while the third write beat is pending, then a normal command must complete.
      fill_data();
      do_txn(1'b1, 32'hB00, 4'd3, 4'd8, 2'b00, 3, 1'b0, 0, 2, 2'b00, 4);
      fill_data();
      do_txn(1'b1, 32'hC00, 4'd2, 4'd10, 2'b00, 2, 1'b0, 0, 0, 2'b00, 3);

      for (int n = 0; n < 24; n++) begin
         bit          wr;
         int          len, rlast_at, sel;
         logic [1:0]  bresp_v;
         bit          bad_id;
         fill_data();
         wr = 1'($urandom_range(0, 1));
         len = $urandom_range(0, 15);
         bresp_v = 2'($urandom_range(0, 3));
         bad_id = ($urandom_range(0, 7) == 0);
         for (int i = 0; i < 16; i++)
            if ($urandom_range(0, 3) == 0) rresp_a[i] = 2'($urandom_range(0, 3));
         sel = $urandom_range(0, 3);
         rlast_at = (sel == 0) ? 99 : (sel == 1) ? $urandom_range(0, len) : len;
         do_txn(wr, $urandom & 32'hFFFF_FFFC, 4'(len), 4'($urandom_range(0, 15)), bresp_v,
                rlast_at, bad_id, 1, 0, model_resp(wr, bresp_v, bad_id, len, rlast_at),
                model_beats(wr, len, rlast_at));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
